// File: rtl/scan_mux.sv
// Purpose: registered channel selector with a live mode (static select) and a round-robin scan mode with a valid/ready handshake and programmable dwell.
// Latency: one clock from data_i/sel_i to out_o in live mode; in scan mode a sample appears one clock after its SAMPLE cycle.
// Backpressure: out_o/chan_o are held while out_valid_o && !out_ready_i in scan mode; out_ready_i is ignored in live mode.
module scan_mux #(
    parameter int CHANNELS = 16,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 4,
    parameter int DWELL_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [DWELL_W-1:0]        dwell_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    output logic [WIDTH-1:0]          out_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [SEL_W-1:0]          chan_o,
    output logic                      wrap_o,
    output logic                      sel_err_o,
    output logic                      busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LIVE    = 3'd1,
        SAMPLE  = 3'd2,
        PRESENT = 3'd3,
        DWELL   = 3'd4
    } state_t;

    // Compare in one extra bit so CHANNELS == 2**SEL_W does not overflow.
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

    state_t               state;
    logic [SEL_W-1:0]     idx;
    logic [DWELL_W-1:0]   cnt;
    logic                 stop_lat;

    logic [WIDTH-1:0]     live_dat;
    logic [WIDTH-1:0]     scan_dat;
    logic                 live_bad;
    logic                 idx_last;
    logic [SEL_W-1:0]     idx_next;

    // Channel pick for both select sources; an out-of-range select yields zero instead of X.
    always_comb begin
        live_dat = '0;
        scan_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_i == SEL_W'(k)) live_dat = data_i[k*WIDTH +: WIDTH];
            if (idx == SEL_W'(k))   scan_dat = data_i[k*WIDTH +: WIDTH];
        end
    end

    assign live_bad = ({1'b0, sel_i} >= CH_LIM);
    assign idx_last = (idx == LAST_IDX);
    assign idx_next = idx_last ? '0 : idx + SEL_W'(1);
    assign busy_o   = (state == SAMPLE) || (state == PRESENT) || (state == DWELL);

    // Mode/scan state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            stop_lat    <= 1'b0;
            out_o       <= '0;
            out_valid_o <= 1'b0;
            chan_o      <= '0;
            wrap_o      <= 1'b0;
            sel_err_o   <= 1'b0;
        end else begin
            wrap_o <= 1'b0;
            if (state == IDLE) begin
                out_valid_o <= 1'b0;
                stop_lat    <= 1'b0;
                if (!mode_i) begin
                    state <= LIVE;
                end else if (start_i) begin
                    state <= SAMPLE;
                    idx   <= '0;
                end
            end else if (state == LIVE) begin
                if (mode_i) begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                    sel_err_o   <= 1'b0;
                end else begin
                    out_o       <= live_bad ? '0 : live_dat;
                    chan_o      <= sel_i;
                    out_valid_o <= 1'b1;
                    sel_err_o   <= live_bad;
                end
            end else if (!mode_i) begin
                // Leaving scan mode drops whatever sample is pending.
                state       <= IDLE;
                out_valid_o <= 1'b0;
                stop_lat    <= 1'b0;
            end else begin
                if (stop_i) stop_lat <= 1'b1;
                if (state == SAMPLE) begin
                    out_o       <= scan_dat;
                    chan_o      <= idx;
                    out_valid_o <= 1'b1;
                    state       <= PRESENT;
                end else if (state == PRESENT) begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        if (stop_lat || stop_i) begin
                            state    <= IDLE;
                            stop_lat <= 1'b0;
                        end else if (dwell_i == '0) begin
                            idx    <= idx_next;
                            wrap_o <= idx_last;
                            state  <= SAMPLE;
                        end else begin
                            cnt   <= dwell_i;
                            state <= DWELL;
                        end
                    end
                end else begin
                    // DWELL: the count loaded at accept is the number of cycles spent here.
                    if (cnt <= DWELL_W'(1)) begin
                        idx    <= idx_next;
                        wrap_o <= idx_last;
                        state  <= SAMPLE;
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench: a 16-channel live-mode instance and a 4-channel scan-mode instance share control inputs.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every check compares against hand-computed constants.
module tb_scan_mux;

    logic         clk;
    logic         rst_n;
    logic         mode, start, stop, ready;
    logic [7:0]   dwell;

    logic [127:0] data_a;
    logic [4:0]   sel_a;
    logic [7:0]   out_a;
    logic         vld_a, wrap_a, err_a, busy_a;
    logic [4:0]   chan_a;

    logic [31:0]  data_b;
    logic [1:0]   sel_b;
    logic [7:0]   out_b;
    logic         vld_b, wrap_b, err_b, busy_b;
    logic [1:0]   chan_b;

    int errors = 0;
    int checks = 0;
    int n;
    logic saw_wrap;

    scan_mux #(.CHANNELS(16), .WIDTH(8), .SEL_W(5), .DWELL_W(8)) u_live (
        .clk(clk), .rst_n(rst_n), .data_i(data_a), .mode_i(mode), .sel_i(sel_a),
        .dwell_i(dwell), .start_i(start), .stop_i(stop), .out_o(out_a),
        .out_valid_o(vld_a), .out_ready_i(ready), .chan_o(chan_a), .wrap_o(wrap_a),
        .sel_err_o(err_a), .busy_o(busy_a)
    );

    scan_mux #(.CHANNELS(4), .WIDTH(8), .SEL_W(2), .DWELL_W(8)) u_scan (
        .clk(clk), .rst_n(rst_n), .data_i(data_b), .mode_i(mode), .sel_i(sel_b),
        .dwell_i(dwell), .start_i(start), .stop_i(stop), .out_o(out_b),
        .out_valid_o(vld_b), .out_ready_i(ready), .chan_o(chan_b), .wrap_o(wrap_b),
        .sel_err_o(err_b), .busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1;
        dwell = 8'd0; sel_a = 5'd0; sel_b = 2'd0;
        for (int k = 0; k < 16; k++) data_a[k*8 +: 8] = 8'(k * 3);
        for (int k = 0; k < 4; k++)  data_b[k*8 +: 8] = 8'(8'hA0 + k);
        tick(); tick();

        // Reset state
        chk("rst_out_a", out_a, 0);   chk("rst_vld_a", vld_a, 0);
        chk("rst_chan_a", chan_a, 0); chk("rst_err_a", err_a, 0);
        chk("rst_busy_a", busy_a, 0); chk("rst_out_b", out_b, 0);
        chk("rst_vld_b", vld_b, 0);   chk("rst_wrap_b", wrap_b, 0);
        chk("rst_busy_b", busy_b, 0);

        // Live mode: IDLE -> LIVE costs one cycle, then one-clock latency
        rst_n = 1'b1; mode = 1'b0; sel_a = 5'd5;
        tick(); chk("live_enter_vld", vld_a, 0);
        tick();
        chk("live_out5", out_a, 15); chk("live_chan5", chan_a, 5);
        chk("live_vld", vld_a, 1);   chk("live_err0", err_a, 0);
        sel_a = 5'd20;
        tick();
        chk("live_oor_out", out_a, 0); chk("live_oor_err", err_a, 1);
        chk("live_oor_vld", vld_a, 1); chk("live_oor_chan", chan_a, 20);
        sel_a = 5'd9;
        tick();
        chk("live_out9", out_a, 27); chk("live_err_clr", err_a, 0);
        mode = 1'b1;
        tick();
        chk("live_exit_vld", vld_a, 0); chk("live_exit_busy", busy_a, 0);

        // Scan, full ready, no dwell: one sample every two cycles
        dwell = 8'd0; ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk("scan_busy", busy_b, 1); chk("scan_first_vld", vld_b, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("scan_out%0d", i), out_b, 32'(8'hA0 + (i % 4)));
            chk($sformatf("scan_chan%0d", i), chan_b, 32'(i % 4));
            chk($sformatf("scan_vld%0d", i), vld_b, 1);
            chk($sformatf("scan_wrap_p%0d", i), wrap_b, 0);
            tick();
            chk($sformatf("scan_gap_vld%0d", i), vld_b, 0);
            chk($sformatf("scan_wrap%0d", i), wrap_b, (i == 3) ? 1 : 0);
        end
        tick(); chk("scan_ch1_again", chan_b, 1);
        tick();
        ready = 1'b0;
        tick();

        // Backpressure on ch2 for 10 cycles while data_i changes underneath
        for (int k = 0; k < 4; k++) data_b[k*8 +: 8] = 8'(8'h50 + k);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_out_c%0d", c), out_b, 32'hA2);
            chk($sformatf("bp_chan_c%0d", c), chan_b, 2);
            chk($sformatf("bp_vld_c%0d", c), vld_b, 1);
            if (c < 9) tick();
        end
        ready = 1'b1;
        tick(); chk("bp_accept_vld", vld_b, 0);
        tick(); chk("bp_next_out", out_b, 32'h53); chk("bp_next_chan", chan_b, 3);

        // Dwell 3: 3 DWELL cycles + 1 SAMPLE cycle with valid low; change to 1 mid-dwell
        dwell = 8'd3; n = 0; saw_wrap = 1'b0;
        tick();
        while (!vld_b && n < 20) begin
            n++;
            saw_wrap |= wrap_b;
            if (n == 1) dwell = 8'd1;
            tick();
        end
        chk("dwell3_gap", n, 4);
        chk("dwell3_wrap", saw_wrap, 1);
        chk("dwell3_out", out_b, 32'h50); chk("dwell3_chan", chan_b, 0);
        n = 0;
        tick();
        while (!vld_b && n < 20) begin
            n++;
            tick();
        end
        chk("dwell1_gap", n, 2);
        chk("dwell1_out", out_b, 32'h51); chk("dwell1_chan", chan_b, 1);

        // Stop during dwell after ch1: ch2 presented once, then IDLE
        dwell = 8'd2;
        tick();
        stop = 1'b1;
        tick(); stop = 1'b0;
        tick();
        tick();
        chk("stop_chan", chan_b, 2); chk("stop_out", out_b, 32'h52); chk("stop_vld", vld_b, 1);
        tick();
        chk("stop_idle_vld", vld_b, 0); chk("stop_idle_busy", busy_b, 0);
        tick();
        chk("stop_stay_idle", busy_b, 0);

        // Abort: mode_i drops during PRESENT
        dwell = 8'd0; ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0; ready = 1'b0;
        tick();
        chk("abort_restart_chan", chan_b, 0); chk("abort_pres_vld", vld_b, 1);
        mode = 1'b0; sel_b = 2'd2;
        tick();
        chk("abort_vld", vld_b, 0); chk("abort_busy", busy_b, 0);
        tick();
        tick();
        chk("abort_live_out", out_b, 32'h52); chk("abort_live_chan", chan_b, 2);
        chk("abort_live_vld", vld_b, 1);

        // Async reset during PRESENT of ch1, then restart at ch0
        mode = 1'b1;
        tick();
        ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick();
        ready = 1'b0;
        tick();
        chk("ares_pre_chan", chan_b, 1); chk("ares_pre_vld", vld_b, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ares_out", out_b, 0);   chk("ares_vld", vld_b, 0);
        chk("ares_chan", chan_b, 0); chk("ares_busy", busy_b, 0);
        tick();
        rst_n = 1'b1; ready = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("ares_restart_chan", chan_b, 0); chk("ares_restart_out", out_b, 32'h50);
        chk("ares_restart_vld", vld_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
